// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline hazard controller for a classic 5-stage in-order core.
//   Resolves three stall/flush sources with fixed priority:
//     memory wait  >  load-use  >  control redirect.
//   A small two-state FSM (RUN / MEM_WAIT) tracks outstanding data-memory
//   accesses so a wait counter can flag a memory that never answers.
//
// Ports
//   clk, reset          rising-edge clock, async active-high reset
//   ID_EX_MemRead       instruction in ID/EX is a load
//   ID_EX_Rt [4:0]      load destination register in ID/EX
//   IF_ID_Rs/Rt [4:0]   source registers of the IF/ID instruction
//   IF_ID_UsesRt        IF/ID instruction actually reads Rt
//   Branch_Taken, Jump  redirect resolved in ID this cycle
//   Mem_Req             EX/MEM data access active (held until accepted)
//   Mem_Ready           data memory completes the access this cycle
//   PC_Write            PC update enable
//   IF_ID_Write         IF/ID update enable (0 = hold)
//   IF_Flush            clear IF/ID at the next edge
//   ID_EX_Bubble        zero ID/EX control at the next edge
//   Pipe_Freeze         hold ID/EX, EX/MEM and MEM/WB
//   Mem_Timeout         sticky: memory wait ran past 255 cycles
//   Stall_Count [15:0]  saturating count of cycles with PC_Write=0
//   Flush_Count [15:0]  saturating count of cycles with IF_Flush=1
// -----------------------------------------------------------------------------
module hazard_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        ID_EX_MemRead,
   input  logic [4:0]  ID_EX_Rt,
   input  logic [4:0]  IF_ID_Rs,
   input  logic [4:0]  IF_ID_Rt,
   input  logic        IF_ID_UsesRt,
   input  logic        Branch_Taken,
   input  logic        Jump,
   input  logic        Mem_Req,
   input  logic        Mem_Ready,
   output logic        PC_Write,
   output logic        IF_ID_Write,
   output logic        IF_Flush,
   output logic        ID_EX_Bubble,
   output logic        Pipe_Freeze,
   output logic        Mem_Timeout,
   output logic [15:0] Stall_Count,
   output logic [15:0] Flush_Count
);

   typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt;
   logic       mem_stall, load_use, redirect;

   // Hazard detection. Register 0 is hardwired zero, so a load "to r0"
   // never creates a dependency.
   assign mem_stall = Mem_Req && !Mem_Ready;
   assign load_use  = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                      ((ID_EX_Rt == IF_ID_Rs) ||
                       (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
   assign redirect  = Branch_Taken || Jump;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   // Next state and control outputs. Outputs depend only on the current
   // hazard conditions; reset forces the free-running defaults so the
   // front end is never held while the block is being cleared.
   always_comb begin
      state_nxt    = state;
      PC_Write     = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_Flush     = 1'b0;
      ID_EX_Bubble = 1'b0;
      Pipe_Freeze  = 1'b0;

      case (state)
         RUN:      if (mem_stall) state_nxt = MEM_WAIT;
         MEM_WAIT: if (Mem_Ready) state_nxt = RUN;
         default:  state_nxt = RUN;
      endcase

      if (!reset) begin
         if (mem_stall) begin
            Pipe_Freeze = 1'b1;
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
         end else if (load_use) begin
            // Redirect is dropped: its operands come from the stalled load.
            PC_Write     = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
         end else if (redirect) begin
            IF_Flush = 1'b1;
         end
      end
   end

   // Wait counter: zeroed on the edge that enters MEM_WAIT, then counts
   // cycles spent waiting and sticks at 255.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wait_cnt <= 8'd0;
      else if (state == RUN && mem_stall)
         wait_cnt <= 8'd0;
      else if (state == MEM_WAIT && wait_cnt != 8'hFF)
         wait_cnt <= wait_cnt + 8'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         Mem_Timeout <= 1'b0;
      else if (state == MEM_WAIT && wait_cnt == 8'hFF && !Mem_Ready)
         Mem_Timeout <= 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Stall_Count <= 16'd0;
         Flush_Count <= 16'd0;
      end else begin
         if (!PC_Write && Stall_Count != 16'hFFFF)
            Stall_Count <= Stall_Count + 16'd1;
         if (IF_Flush && Flush_Count != 16'hFFFF)
            Flush_Count <= Flush_Count + 16'd1;
      end
   end

endmodule
